conv_mac_sequencer: RTL and testbench

CONV_MAC_SEQUENCER -- requirements
Module: conv_mac_sequencer

---
 rtl/conv_mac_sequencer_if.sv | 29 ++
 rtl/conv_mac_sequencer.sv | 118 +++++++++++
 tb/tb_conv_mac_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_sequencer_if.sv
// Signal bundle between the convolution MAC sequencer and its surroundings:
// coefficient writes, sample input, external MAC operands/result and result output.
interface conv_mac_sequencer_if;
  logic               coef_we;
  logic        [3:0]  coef_addr;
  logic signed [7:0]  coef_data;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  in_data;
  logic signed [7:0]  mac_x;
  logic signed [7:0]  mac_y;
  logic               mac_accum_reset;
  logic signed [31:0] mac_result;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               busy;

  modport master (
    output coef_we, coef_addr, coef_data, flush, in_valid, in_data, mac_result, out_ready,
    input  in_ready, mac_x, mac_y, mac_accum_reset, out_valid, out_data, busy
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, flush, in_valid, in_data, mac_result, out_ready,
    output in_ready, mac_x, mac_y, mac_accum_reset, out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Sliding-window FIR sequencer: collects samples into a KLEN-tap window and steps an
// external MAC through one tap per cycle, presenting each convolution result on a handshake.
module conv_mac_sequencer #(
  parameter int unsigned KLEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_mac_sequencer_if.slave  ctrl
);

  localparam int unsigned IdxW  = $clog2(KLEN);
  localparam int unsigned FillW = $clog2(KLEN + 1);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StOut} state_e;

  state_e             state_q, state_d;
  logic signed [7:0]  win_q  [KLEN];
  logic signed [7:0]  win_d  [KLEN];
  logic signed [7:0]  coef_q [KLEN];
  logic signed [7:0]  coef_d [KLEN];
  logic [FillW-1:0]   fill_q, fill_d;
  logic [IdxW-1:0]    tap_q, tap_d;
  logic signed [31:0] out_data_q, out_data_d;
  logic               in_xfer;
  logic               coef_wr;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    coef_d     = coef_q;
    fill_d     = fill_q;
    tap_d      = tap_q;
    out_data_d = out_data_q;

    ctrl.mac_x           = '0;
    ctrl.mac_y           = '0;
    ctrl.mac_accum_reset = rst;
    // flush wins over a coincident sample; nothing is accepted while reset is held
    ctrl.in_ready        = (state_q == StIdle) && !ctrl.flush && !rst;
    ctrl.out_valid       = (state_q == StOut);
    ctrl.out_data        = out_data_q;
    ctrl.busy            = (state_q != StIdle);

    in_xfer = ctrl.in_ready && ctrl.in_valid;
    coef_wr = (state_q == StIdle) && ctrl.coef_we && ({28'd0, ctrl.coef_addr} < KLEN);

    unique case (state_q)
      StIdle: begin
        if (coef_wr) begin
          coef_d[ctrl.coef_addr[IdxW-1:0]] = ctrl.coef_data;
        end
        if (ctrl.flush) begin
          for (int unsigned i = 0; i < KLEN; i++) begin
            win_d[i] = '0;
          end
          fill_d = '0;
        end else if (in_xfer) begin
          win_d[0] = ctrl.in_data;
          for (int unsigned i = 1; i < KLEN; i++) begin
            win_d[i] = win_q[i-1];
          end
          if (fill_q != FillW'(KLEN)) begin
            fill_d = fill_q + 1'b1;
          end
          // window is full once this sample lands
          if (fill_q >= FillW'(KLEN - 1)) begin
            state_d = StClear;
          end
        end
      end
      StClear: begin
        ctrl.mac_accum_reset = 1'b1;
        tap_d                = '0;
        state_d              = StRun;
      end
      StRun: begin
        ctrl.mac_x = win_q[tap_q];
        ctrl.mac_y = coef_q[tap_q];
        tap_d      = tap_q + 1'b1;
        if (tap_q == IdxW'(KLEN - 1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // MAC result is registered, so the last product is visible only now
        out_data_d = ctrl.mac_result;
        state_d    = StOut;
      end
      StOut: begin
        if (ctrl.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      for (int unsigned i = 0; i < KLEN; i++) begin
        win_q[i]  <= '0;
        coef_q[i] <= '0;
      end
      fill_q     <= '0;
      tap_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      coef_q     <= coef_d;
      fill_q     <= fill_d;
      tap_q      <= tap_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer with KLEN=4 and a behavioural MAC in the loop.
module tb_conv_mac_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  conv_mac_sequencer_if bus ();

  conv_mac_sequencer #(.KLEN(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  // external MAC: clear on accum_reset, otherwise accumulate the signed product
  always @(posedge clk) begin
    if (bus.mac_accum_reset) bus.mac_result <= 32'sd0;
    else                     bus.mac_result <= bus.mac_result + bus.mac_x * bus.mac_y;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic signed [7:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr;
    bus.coef_data = data;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic send(input logic signed [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    check("send_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
  endtask

  task automatic get_output(input string tag, input logic signed [31:0] exp, output int n);
    wait_valid(tag, n);
    check(tag, bus.out_data, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_accum_reset", 32'(bus.mac_accum_reset), 1);
    check("rst_out_data", bus.out_data, 0);
    check("rst_mac_x", 32'(bus.mac_x), 0);
    rst = 1'b0;
    tick();

    // basic 1,2,3,4 kernel; out-of-range address must not alias onto tap 0
    write_coef(4'd0, 8'sd1);
    write_coef(4'd1, 8'sd2);
    write_coef(4'd2, 8'sd3);
    write_coef(4'd3, 8'sd4);
    write_coef(4'd4, 8'sd100);
    send(8'sd1);
    check("fill1_busy", 32'(bus.busy), 0);
    send(8'sd1);
    check("fill2_busy", 32'(bus.busy), 0);
    send(8'sd1);
    check("fill3_busy", 32'(bus.busy), 0);
    send(8'sd1);
    check("clear_accum_reset", 32'(bus.mac_accum_reset), 1);
    check("clear_in_ready", 32'(bus.in_ready), 0);
    get_output("sum_ones", 32'sd10, lat);
    check("latency", lat, 6);

    // result held while out_ready low; sample pulses must be ignored
    send(8'sd2);
    wait_valid("hold", lat);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = (k % 2 == 0);
      bus.in_data  = 8'sd50;
      #1;
      check("hold_in_ready", 32'(bus.in_ready), 0);
      check("hold_data", bus.out_data, 32'sd11);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hold_release_idle", 32'(bus.busy), 0);
    send(8'sd3);
    get_output("after_hold", 32'sd14, lat);

    // coefficient write during RUN is dropped
    send(8'sd1);
    tick();
    check("run0_mac_x", 32'(bus.mac_x), 1);
    check("run0_mac_y", 32'(bus.mac_y), 1);
    tick();
    check("run1_mac_x", 32'(bus.mac_x), 3);
    check("run1_mac_y", 32'(bus.mac_y), 2);
    tick();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd0;
    bus.coef_data = 8'sd5;
    tick();
    bus.coef_we   = 1'b0;
    get_output("run_write_cur", 32'sd17, lat);
    send(8'sd2);
    get_output("run_write_next", 32'sd21, lat);

    // same-cycle coefficient write and sample transfer both land
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd0;
    bus.coef_data = 8'sd5;
    send(8'sd1);
    bus.coef_we   = 1'b0;
    get_output("same_cycle", 32'sd24, lat);

    // reset in RUN cycle 2 aborts; 3 samples then refill give no output
    send(8'sd4);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_in_ready", 32'(bus.in_ready), 0);
    check("abort_accum_reset", 32'(bus.mac_accum_reset), 1);
    check("abort_mac_x", 32'(bus.mac_x), 0);
    check("abort_mac_y", 32'(bus.mac_y), 0);
    check("abort_out_data", bus.out_data, 0);
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      send(-8'sd128);
      check("post_rst_quiet", 32'(bus.busy), 0);
    end
    repeat (8) tick();
    check("post_rst_no_out", 32'(bus.out_valid), 0);
    for (int a = 0; a < 4; a++) write_coef(4'(a), -8'sd128);
    send(-8'sd128);
    get_output("neg_full", 32'sd65536, lat);
    check("neg_latency", lat, 6);
    send(8'sd0);
    get_output("neg_slide", 32'sd49152, lat);

    // flush beats a coincident sample and empties the window
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd7;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_busy", 32'(bus.busy), 0);
    for (int k = 0; k < 3; k++) begin
      send(8'sd1);
      check("post_flush_quiet", 32'(bus.busy), 0);
    end
    send(8'sd1);
    get_output("post_flush", -32'sd512, lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
